// File: rtl/mul_div_unit.sv
// Iterative MIPS32 MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// Define MDU_FAST_MULT_EN to compute multiplies in one step.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  st;
  logic [4:0]  cnt;
  logic        isdiv;
  logic        nq;
  logic        nr;
  logic        dz;
  logic [63:0] acc;
  logic [31:0] opb;

  logic        sgn;
  logic        ismd;
  logic        isdv;
  logic [31:0] aa;
  logic [31:0] bb;

  assign sgn  = ~MDOp[0];
  assign ismd = ~MDOp[2];
  assign isdv = MDOp[1];
  assign aa   = (sgn && A[31]) ? -A : A;
  assign bb   = (sgn && B[31]) ? -B : B;

  // shift-add step: low half holds the remaining multiplier bits
  logic [32:0] msum;
  logic [63:0] mnext;

  assign msum  = {1'b0, acc[63:32]}
               + (acc[0] ? {1'b0, opb} : 33'd0);
  assign mnext = {msum, acc[31:1]};

  // restoring step: upper half is the partial remainder
  logic [32:0] dt;
  logic [31:0] dd;
  logic        dge;
  logic [63:0] dnext;

  assign dt    = acc[63:31];
  assign dge   = dt >= {1'b0, opb};
  assign dd    = dt[31:0] - opb;
  assign dnext = {dge ? dd : dt[31:0], acc[30:0], dge};

  logic [63:0] pfix;
  logic [31:0] qfix;
  logic [31:0] rfix;

  assign pfix = nq ? -acc : acc;
  assign qfix = dz ? 32'hFFFF_FFFF
              : (nq ? -acc[31:0] : acc[31:0]);
  assign rfix = nr ? -acc[63:32] : acc[63:32];

`ifdef MDU_FAST_MULT_EN
  logic [63:0] fprod;

  assign fprod = {32'd0, aa} * {32'd0, bb};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= IDLE;
      cnt   <= 5'd0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      isdiv <= 1'b0;
      nq    <= 1'b0;
      nr    <= 1'b0;
      dz    <= 1'b0;
      acc   <= 64'd0;
      opb   <= 32'd0;
    end else begin
      Done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (Start) begin
            if (ismd) begin
              Busy  <= 1'b1;
              cnt   <= 5'd0;
              isdiv <= isdv;
              nq    <= sgn && (A[31] ^ B[31]);
              nr    <= sgn && A[31];
              dz    <= (B == 32'd0);
              if (isdv) begin
                acc <= {32'd0, aa};
                opb <= bb;
                st  <= CALC;
              end else begin
`ifdef MDU_FAST_MULT_EN
                acc <= fprod;
                st  <= FIX;
`else
                acc <= {32'd0, bb};
                opb <= aa;
                st  <= CALC;
`endif
              end
            end else if (MDOp == 3'b100) begin
              HI <= A;
            end else if (MDOp == 3'b101) begin
              LO <= A;
            end
          end
        end
        CALC: begin
          acc <= isdiv ? dnext : mnext;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            st <= FIX;
        end
        FIX: begin
          if (isdiv) begin
            HI <= rfix;
            LO <= qfix;
          end else begin
            {HI, LO} <= pfix;
          end
          Done <= 1'b1;
          Busy <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table, corner
// sequences and random ops against an arithmetic model.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDOp  (MDOp),
    .Start (Start),
    .Busy  (Busy),
    .Done  (Done),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        tbl [10];
  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] ehi,
                        input logic [31:0] elo,
                        input int          poke,
                        input string       nm);
    int lat;
    int n;
    bit got;
    lat = 33;
`ifdef MDU_FAST_MULT_EN
    if (op[2:1] == 2'b00) lat = 1;
`endif
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    @(posedge clk); #1;
    chk({nm, "_busy_acc"}, 64'(Busy), 64'd1);
    chk({nm, "_done_acc"}, 64'(Done), 64'd0);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    MDOp  = 3'($urandom_range(0, 7));
    n     = 0;
    got   = 1'b0;
    while (!got && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (poke > 0 && n == poke) begin
        Start = 1'b1;
        MDOp  = 3'b001;
        A     = $urandom;
        B     = $urandom;
      end else begin
        Start = 1'b0;
      end
      if (lat > 2 && n == 2)
        chk({nm, "_hold"}, {HI, LO}, {mhi, mlo});
      if (lat > 1 && n == lat - 1)
        chk({nm, "_busy_mid"}, 64'(Busy), 64'd1);
      if (Done) got = 1'b1;
    end
    Start = 1'b0;
    chk({nm, "_latency"}, 64'(n), 64'(lat));
    chk({nm, "_busy_end"}, 64'(Busy), 64'd0);
    chk({nm, "_hi"}, 64'(HI), 64'(ehi));
    chk({nm, "_lo"}, 64'(LO), 64'(elo));
    mhi = ehi;
    mlo = elo;
  endtask

  task automatic mt(input logic hi, input logic [31:0] v);
    Start = 1'b1;
    MDOp  = hi ? 3'b100 : 3'b101;
    A     = v;
    @(posedge clk); #1;
    Start = 1'b0;
    if (hi) mhi = v;
    else    mlo = v;
    chk("mt_hi", 64'(HI), 64'(mhi));
    chk("mt_lo", 64'(LO), 64'(mlo));
    chk("mt_busy", 64'(Busy), 64'd0);
    chk("mt_done", 64'(Done), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] e;
    bit          seen;

    tbl[0] = '{3'd1, 32'd12345, 32'd54321, 32'd0, 32'd670592745};
    tbl[1] = '{3'd0, 32'hFFFF_FFFC, 32'd54321, 32'hFFFF_FFFF, 32'hFFFC_AF3C};
    tbl[2] = '{3'd3, 32'd54321, 32'd12345, 32'd4941, 32'd4};
    tbl[3] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4] = '{3'd3, 32'd12345, 32'd0, 32'd12345, 32'hFFFF_FFFF};
    tbl[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    tbl[6] = '{3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD};
    tbl[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    tbl[8] = '{3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[9] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};

    reset = 1'b1;
    Start = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    MDOp  = 3'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);

    mt(1'b1, 32'hDEAD_BEEF);
    mt(1'b0, 32'h1234_5678);

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].hi, tbl[i].lo, 0, $sformatf("vec%0d", i));

    run_op(3'd3, 32'd54321, 32'd12345, 32'd4941, 32'd4,
           10, "ignored_start");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = a >> 20;
        3: b = b >> 24;
        default: ;
      endcase
      e = model(op, a, b);
      run_op(op, a, b, e[63:32], e[31:0], 0, $sformatf("rand%0d", i));
    end

    mt(1'b1, 32'hCAFE_F00D);
    Start = 1'b1;
`ifdef MDU_FAST_MULT_EN
    MDOp  = 3'b011;
`else
    MDOp  = 3'b001;
`endif
    A     = 32'd12345;
    B     = 32'd54321;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_done", 64'(Done), 64'd0);
    chk("abort_hi", 64'(HI), 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done || Busy) seen = 1'b1;
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    mhi = 32'd0;
    mlo = 32'd0;

    run_op(3'd0, 32'hFFFF_FFFC, 32'd54321,
           32'hFFFF_FFFF, 32'hFFFC_AF3C, 0, "post_abort");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
